// File: rtl/cfs_md_packer.sv
// MD byte packer: gathers the valid bytes of sparse MD transfers into a
// full-width accumulator and emits packed words (or a partial word on flush)
// through a small output FIFO. Illegal transfers are flagged and counted.
module cfs_md_packer #(
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int ERR_CNT_WIDTH = 16,
   localparam int BYTES        = DATA_WIDTH / 8,
   localparam int OFFSET_WIDTH = (BYTES > 1) ? $clog2(BYTES) : 1,
   localparam int SIZE_WIDTH   = $clog2(BYTES) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic [OFFSET_WIDTH-1:0]  in_offset,
   input  logic [SIZE_WIDTH-1:0]    in_size,
   output logic                     in_ready,
   output logic                     in_err,
   input  logic                     flush,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [OFFSET_WIDTH-1:0]  out_offset,
   output logic [SIZE_WIDTH-1:0]    out_size,
   input  logic                     out_ready,
   output logic [SIZE_WIDTH-1:0]    fill_bytes,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

   localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
   localparam logic [SIZE_WIDTH:0]    BYTES_X  = (SIZE_WIDTH + 1)'(BYTES);
   localparam logic [SIZE_WIDTH-1:0]  BYTES_S  = SIZE_WIDTH'(BYTES);
   localparam logic [CNT_WIDTH-1:0]   DEPTH_C  = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [PTR_WIDTH-1:0]   LAST_PTR = PTR_WIDTH'(FIFO_DEPTH - 1);

   if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_width
      $error("cfs_md_packer: DATA_WIDTH must be a power of two and >= 8");
   end
   if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("cfs_md_packer: FIFO_DEPTH must be >= 2");
   end

   logic [DATA_WIDTH-1:0]    acc;
   logic [SIZE_WIDTH-1:0]    fill;
   logic                     flush_pending;
   logic [ERR_CNT_WIDTH-1:0] err_count;

   logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
   logic [SIZE_WIDTH-1:0]    fifo_size [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]     rd_ptr;
   logic [PTR_WIDTH-1:0]     wr_ptr;
   logic [CNT_WIDTH-1:0]     count;

   logic                     fifo_full;
   logic                     accept;
   logic                     illegal;
   logic                     legal;
   logic [SIZE_WIDTH:0]      span;
   logic [SIZE_WIDTH:0]      total;
   logic [SIZE_WIDTH:0]      remain;
   logic                     wraps;
   logic [DATA_WIDTH-1:0]    sel_mask;
   logic [DATA_WIDTH-1:0]    sel_bytes;
   logic [2*DATA_WIDTH-1:0]  merged;
   logic                     flush_exec;
   logic                     push;
   logic                     pop;
   logic [DATA_WIDTH-1:0]    push_data;
   logic [SIZE_WIDTH-1:0]    push_size;

   // Handshake, legality check, byte extraction and merge into the accumulator.
   always_comb begin
      fifo_full  = (count == DEPTH_C);
      in_ready   = !reset && !fifo_full && !flush_pending;
      accept     = in_valid && in_ready;
      span       = {1'b0, in_size} + (SIZE_WIDTH + 1)'(in_offset);
      illegal    = (in_size == '0) || (span > BYTES_X);
      in_err     = accept && illegal;
      legal      = accept && !illegal;

      sel_mask = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         if (i < 32'(in_size)) sel_mask[8*i +: 8] = '1;
      end
      sel_bytes = (in_data >> {in_offset, 3'b000}) & sel_mask;
      // Upper half of merged holds the bytes that spill past a full word.
      merged    = {{DATA_WIDTH{1'b0}}, acc} | ({{DATA_WIDTH{1'b0}}, sel_bytes} << {fill, 3'b000});
      total     = {1'b0, fill} + {1'b0, in_size};
      remain    = total - BYTES_X;
      wraps     = (total >= BYTES_X);

      // A pending flush keeps in_ready low, so it never coincides with an accept.
      flush_exec = flush_pending && !fifo_full;
      push       = (legal && wraps) || (flush_exec && (fill != '0));
      push_data  = flush_exec ? acc  : merged[DATA_WIDTH-1:0];
      push_size  = flush_exec ? fill : BYTES_S;
      pop        = (count != '0) && out_ready;

      out_valid  = (count != '0);
      out_data   = out_valid ? fifo_data[rd_ptr] : '0;
      out_size   = out_valid ? fifo_size[rd_ptr] : '0;
      out_offset = '0;
      fill_bytes = fill;
      err_cnt    = err_count;
   end

   // Accumulator, flush request and saturating error counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc           <= '0;
         fill          <= '0;
         flush_pending <= 1'b0;
         err_count     <= '0;
      end else begin
         if (legal) begin
            if (wraps) begin
               acc  <= merged[2*DATA_WIDTH-1:DATA_WIDTH];
               fill <= remain[SIZE_WIDTH-1:0];
            end else begin
               acc  <= merged[DATA_WIDTH-1:0];
               fill <= total[SIZE_WIDTH-1:0];
            end
         end else if (flush_exec) begin
            acc  <= '0;
            fill <= '0;
         end
         if (flush_exec)  flush_pending <= 1'b0;
         else if (flush)  flush_pending <= 1'b1;
         if (in_err && (err_count != '1)) err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
   end

   // FIFO storage; entries need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= push_data;
         fifo_size[wr_ptr] <= push_size;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_WIDTH'(1);
            2'b01:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_cfs_md_packer.sv
// Scoreboard bench for cfs_md_packer: a byte-queue reference model predicts
// packed words, handshake flags, fill level and error count.
module tb_cfs_md_packer;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int EW    = 16;
   localparam int BYTES = DW / 8;
   localparam int OW    = 2;
   localparam int SW    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [OW-1:0] in_offset = '0;
   logic [SW-1:0] in_size = '0;
   logic          in_ready, in_err;
   logic          flush = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [OW-1:0] out_offset;
   logic [SW-1:0] out_size;
   logic          out_ready = 1'b0;
   logic [SW-1:0] fill_bytes;
   logic [EW-1:0] err_cnt;

   cfs_md_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(EW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_offset(in_offset), .in_size(in_size), .in_ready(in_ready), .in_err(in_err),
      .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_offset(out_offset),
      .out_size(out_size), .out_ready(out_ready), .fill_bytes(fill_bytes), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      int            size;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] bq[$];
   int         occ = 0;
   bit         m_pending = 0;
   int         m_err = 0;
   bit         m_acc, m_illegal, m_pop, m_exec;
   int         pushes;
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void emit(input int n);
      logic [DW-1:0] w;
      w = '0;
      for (int j = 0; j < n; j++) w = w | (DW'(bq.pop_front()) << (8 * j));
      sbq.push_back('{w, n});
      pushes++;
   endfunction

   // One clock cycle: check combinational outputs at negedge, advance model at posedge.
   task automatic tick();
      bit exp_ready;
      @(negedge clk);
      exp_ready = !reset && (occ < DEPTH) && !m_pending;
      m_illegal = (in_size == 0) || (int'(in_offset) + int'(in_size) > BYTES);
      m_acc     = in_valid && exp_ready;
      m_pop     = (occ > 0) && out_ready;
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("in_err", 64'(in_err), 64'(m_acc && m_illegal));
      chk("fill_bytes", 64'(fill_bytes), 64'(bq.size()));
      chk("err_cnt", 64'(err_cnt), 64'(m_err));
      chk("out_valid", 64'(out_valid), 64'(occ > 0));
      @(posedge clk);
      if (reset) begin
         bq.delete();
         sbq.delete();
         occ = 0;
         m_pending = 0;
         m_err = 0;
      end else begin
         pushes = 0;
         m_exec = m_pending && (occ < DEPTH) && !m_acc;
         if (m_acc && m_illegal) begin
            if (m_err != 65535) m_err++;
         end else if (m_acc) begin
            for (int i = 0; i < int'(in_size); i++)
               bq.push_back(8'(in_data >> (8 * (int'(in_offset) + i))));
            if (bq.size() >= BYTES) emit(BYTES);
         end else if (m_exec && bq.size() > 0) begin
            emit(bq.size());
         end
         if (m_exec) m_pending = 0;
         else if (flush) m_pending = 1;
         occ = occ + pushes - (m_pop ? 1 : 0);
      end
      #1;
   endtask

   task automatic xfer(input int off, input int size, input logic [DW-1:0] data, input bit fl);
      bit done;
      done = 0;
      in_valid = 1'b1; in_offset = OW'(off); in_size = SW'(size); in_data = data; flush = fl;
      for (int k = 0; k < 40 && !done; k++) begin
         tick();
         flush = 1'b0;
         done = m_acc;
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL xfer_timeout: got no accept expected accept");
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 100 && (occ > 0 || m_pending); k++) tick();
      chk("drain_done", 64'(occ), 64'd0);
   endtask

   // Monitor: pops the scoreboard on every output handshake, checks stall stability.
   initial begin
      exp_t          e;
      bit            stall;
      logic [DW-1:0] held_d;
      logic [SW-1:0] held_s;
      stall = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall = 0;
         end else begin
            if (stall) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_data", 64'(out_data), 64'(held_d));
               chk("hold_size", 64'(out_size), 64'(held_s));
            end
            if (out_valid && out_ready) begin
               stall = 0;
               if (sbq.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_out: got data %0h expected no output", out_data);
               end else begin
                  e = sbq.pop_front();
                  chk("out_data", 64'(out_data), 64'(e.data));
                  chk("out_size", 64'(out_size), 64'(e.size));
                  chk("out_offset", 64'(out_offset), 64'd0);
               end
            end else if (out_valid) begin
               stall = 1; held_d = out_data; held_s = out_size;
            end else begin
               stall = 0;
            end
         end
      end
   end

   initial begin
      idle(2);
      reset = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_size", 64'(out_size), 64'd0);
      out_ready = 1'b1;

      // four single bytes -> 0x44332211
      xfer(0, 1, 32'h11, 0); xfer(0, 1, 32'h22, 0);
      xfer(0, 1, 32'h33, 0); xfer(0, 1, 32'h44, 0);
      idle(2);

      // offset/wrap case then flush of the leftover byte
      xfer(1, 3, 32'hDDCCBBAA, 0);
      xfer(0, 2, 32'h0000FFEE, 0);
      idle(1);
      flush = 1'b1; tick(); flush = 1'b0;
      idle(3);

      // illegal transfers, then a legal one, then clear
      xfer(0, 0, 32'h12345678, 0);
      xfer(3, 2, 32'h12345678, 0);
      xfer(2, 2, 32'hA1B2C3D4, 0);
      flush = 1'b1; tick(); flush = 1'b0;
      idle(3);

      // back-pressure: four words fill the FIFO, fifth waits for release
      out_ready = 1'b0;
      for (int w = 0; w < 4; w++) xfer(0, 4, $urandom, 0);
      in_valid = 1'b1; in_offset = '0; in_size = 3'd4; in_data = $urandom;
      idle(3);
      out_ready = 1'b1;
      xfer(0, 4, in_data, 0);
      idle(6);

      // flush with a concurrent accept, then flush on empty accumulator
      xfer(0, 2, 32'h0000BEEF, 1);
      idle(3);
      flush = 1'b1; tick(); flush = 1'b0;
      idle(3);

      // reset with queued words and a partial accumulator
      out_ready = 1'b0;
      xfer(0, 4, $urandom, 0); xfer(0, 4, $urandom, 0); xfer(1, 3, $urandom, 0);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      chk("post_rst_fill", 64'(fill_bytes), 64'd0);
      chk("post_rst_err", 64'(err_cnt), 64'd0);
      out_ready = 1'b1;
      idle(5);

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_offset = OW'($urandom_range(0, 3));
         in_size   = SW'($urandom_range(0, 4));
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0;
      drain();
      idle(2);
      chk("sb_empty", 64'(sbq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
